mac_signed_pipe: RTL
====================

MAC_SIGNED_PIPE -- requirements
Module: mac_signed_pipe

Interface
REQ-001 The block SHALL have these parameters:
- AW, default 16, width of signed operand a.
- BW, default 16, width of signed operand b.
- CW, default 16, width of signed addend c.
- PW, default 48, width of signed result/accumulator; PW >= AW+BW+1 and PW >= CW.

REQ-002 The block SHALL have these ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
- ce  in  1  clock enable for all pipeline and accumulator registers.
- sclr  in  1  synchronous clear.
- in_valid  in  1  input sample qualifier.
- a  in  AW  signed two's-complement multiplicand.
- b  in  BW  signed two's-complement multiplier.
- c  in  CW  signed two's-complement addend.
- mode  in  2  operation select, sampled with a/b/c.
- p  out  PW  signed result.
- p_valid  out  1  p holds a new result.
- pcout  out  PW  cascade output.
- ovf  out  1  sticky signed-overflow flag.

Function
REQ-003 Operation SHALL be selected by mode: 00 = P=A*B+C; 01 = P=C-A*B; 10 = ACC=ACC+A*B; 11 = ACC=ACC-A*B.
REQ-004 The pipeline SHALL have 3 register stages.
- S1 registers a, b, c, mode and in_valid.
- S2 registers the full-precision signed product (AW+BW bits) and carries c, mode and valid.
- S3 registers p and p_valid.
REQ-005 Latency SHALL be 3 ce-qualified rising edges from the sample edge to p/p_valid.
- Throughput SHALL be one sample per ce-qualified cycle.
REQ-006 The product and c SHALL be sign-extended to PW before add/subtract.
- Arithmetic SHALL be modulo 2^PW (wrap, no saturation).
REQ-007 In modes 10/11 the accumulator SHALL be the S3 register p.
- It SHALL update only when the S3-bound sample is valid.
- Invalid samples SHALL leave p unchanged and produce p_valid=0.
REQ-008 In modes 00/01, p SHALL be loaded only by valid samples.
- A valid 00/01 sample followed by a 10/11 sample SHALL seed the accumulation from that loaded p.
REQ-009 pcout SHALL equal p on every cycle.
REQ-010 ovf SHALL set to 1 when a valid S3 add/subtract produces signed overflow, i.e. both operands have the same sign and the result sign differs (operands: ACC or C, and the ±product).
- Once set, ovf SHALL stay 1 until sclr or reset.
REQ-011 When ce=0, all registers (S1, S2, p, p_valid, ovf) SHALL hold their values; inputs SHALL be ignored.
REQ-012 sclr=1 at a rising edge SHALL zero all registers (S1, S2, p, p_valid, ovf).
- sclr SHALL act regardless of ce; sclr has priority over ce.
REQ-013 Samples in flight when sclr is asserted SHALL be discarded.
- No p_valid pulse SHALL result from them.
REQ-014 p_valid SHALL be asserted for exactly one ce-qualified cycle per valid input sample, in input order.

Reset
REQ-015 rst_n=0 SHALL immediately and asynchronously clear all registers: p=0, pcout=0, p_valid=0, ovf=0, S1/S2 contents and valids=0.
REQ-016 rst_n assertion SHALL take effect mid-operation regardless of ce or sclr.
REQ-017 After rst_n deasserts, the first valid sample SHALL produce a result on the 3rd ce-qualified edge.

Verification
REQ-018 Mode 00: a=-8, b=37, c=-6, in_valid=1, ce=1 for one sample -> p=-302 (0xFFFF_FFFF_FED2 at PW=48), p_valid=1 on the 3rd edge only, ovf=0.
REQ-019 Mode 01 with the same operands -> p=290; then b=9 -> p=66, producing back-to-back p_valid pulses on consecutive cycles.
REQ-020 Accumulate sequence:
- Stimulus: mode 00 sample a=0, b=0, c=0, then three mode 10 samples a=-8, b=37.
- Required: p goes 0, -296, -592, -888.
- Then one mode 11 sample a=2, b=9 -> p=-906.
REQ-021 ce gating and sclr:
- Drop ce for 5 cycles with 2 samples in flight -> p, p_valid and pipeline frozen; results emerge after ce returns with total latency 3 ce edges.
- Pulse sclr with 2 samples in flight -> p=0, no p_valid pulses follow.
REQ-022 Overflow with PW=33:
- Stimulus: mode 00 a=-32768, b=-32768, c=0 (p=2^30), then three mode 10 samples of the same operands.
- Required: the third accumulate wraps p to -2^32 with ovf=1; ovf stays 1 until sclr.
REQ-023 Pull rst_n low mid-accumulation, asynchronously between clock edges -> all outputs 0 before the next clk edge; after release, accumulation restarts from 0.

Source files
------------

// File: rtl/mac_signed_pipe.sv
// Three-stage signed multiply-add / multiply-accumulate pipeline.
// S1 holds operands, S2 holds the full-precision product, S3 holds p (the accumulator).
module mac_signed_pipe #(
  parameter int AW = 16,
  parameter int BW = 16,
  parameter int CW = 16,
  parameter int PW = 48
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 ce,
  input  logic                 sclr,
  input  logic                 in_valid,
  input  logic signed [AW-1:0] a,
  input  logic signed [BW-1:0] b,
  input  logic signed [CW-1:0] c,
  input  logic        [1:0]    mode,
  output logic signed [PW-1:0] p,
  output logic                 p_valid,
  output logic signed [PW-1:0] pcout,
  output logic                 ovf
);

  localparam int MW = AW + BW;

  // S1
  logic signed [AW-1:0] a_q, a_d;
  logic signed [BW-1:0] b_q, b_d;
  logic signed [CW-1:0] c1_q, c1_d;
  logic        [1:0]    mode1_q, mode1_d;
  logic                 v1_q, v1_d;

  // S2
  logic signed [MW-1:0] prod_q, prod_d;
  logic signed [CW-1:0] c2_q, c2_d;
  logic        [1:0]    mode2_q, mode2_d;
  logic                 v2_q, v2_d;

  // S3
  logic signed [PW-1:0] p_q, p_d;
  logic                 pv_q, pv_d;
  logic                 ovf_q, ovf_d;

  logic signed [MW-1:0] prod_full;
  logic signed [PW-1:0] prod_ext;
  logic signed [PW-1:0] c_ext;
  logic signed [PW-1:0] term_a;
  logic signed [PW-1:0] term_b;
  logic signed [PW-1:0] sum;
  logic                 ovf_now;

  // PW >= MW+1, so negating the extended product can never overflow.
  always_comb begin
    prod_full = a_q * b_q;
    prod_ext  = PW'(prod_q);
    c_ext     = PW'(c2_q);
    term_a    = mode2_q[1] ? p_q : c_ext;
    term_b    = mode2_q[0] ? -prod_ext : prod_ext;
    sum       = term_a + term_b;
    ovf_now   = (term_a[PW-1] == term_b[PW-1]) && (sum[PW-1] != term_a[PW-1]);
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    c1_d    = c1_q;
    mode1_d = mode1_q;
    v1_d    = v1_q;
    prod_d  = prod_q;
    c2_d    = c2_q;
    mode2_d = mode2_q;
    v2_d    = v2_q;
    p_d     = p_q;
    pv_d    = pv_q;
    ovf_d   = ovf_q;
    // Clear wins over enable so in-flight samples are dropped even while stalled.
    if (sclr) begin
      a_d     = '0;
      b_d     = '0;
      c1_d    = '0;
      mode1_d = '0;
      v1_d    = 1'b0;
      prod_d  = '0;
      c2_d    = '0;
      mode2_d = '0;
      v2_d    = 1'b0;
      p_d     = '0;
      pv_d    = 1'b0;
      ovf_d   = 1'b0;
    end else if (ce) begin
      a_d     = a;
      b_d     = b;
      c1_d    = c;
      mode1_d = mode;
      v1_d    = in_valid;
      prod_d  = prod_full;
      c2_d    = c1_q;
      mode2_d = mode1_q;
      v2_d    = v1_q;
      p_d     = v2_q ? sum : p_q;
      pv_d    = v2_q;
      ovf_d   = ovf_q | (v2_q & ovf_now);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      c1_q    <= '0;
      mode1_q <= '0;
      v1_q    <= 1'b0;
      prod_q  <= '0;
      c2_q    <= '0;
      mode2_q <= '0;
      v2_q    <= 1'b0;
      p_q     <= '0;
      pv_q    <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      c1_q    <= c1_d;
      mode1_q <= mode1_d;
      v1_q    <= v1_d;
      prod_q  <= prod_d;
      c2_q    <= c2_d;
      mode2_q <= mode2_d;
      v2_q    <= v2_d;
      p_q     <= p_d;
      pv_q    <= pv_d;
      ovf_q   <= ovf_d;
    end
  end

  assign p       = p_q;
  assign pcout   = p_q;
  assign p_valid = pv_q;
  assign ovf     = ovf_q;

endmodule
